// File: rtl/axil_cmd_queue_if.sv
// Bus bundle for axil_cmd_queue: AXI4-Lite slave port plus the command/valid-ready
// port toward the engine. The slave modport is the register file side.
interface axil_cmd_queue_if #(
  parameter int unsigned NREG = 4
) ();
  logic [31:0]        S_AXI_AWADDR;
  logic               S_AXI_AWVALID;
  logic               S_AXI_AWREADY;
  logic [31:0]        S_AXI_WDATA;
  logic [3:0]         S_AXI_WSTRB;
  logic               S_AXI_WVALID;
  logic               S_AXI_WREADY;
  logic [1:0]         S_AXI_BRESP;
  logic               S_AXI_BVALID;
  logic               S_AXI_BREADY;
  logic [31:0]        S_AXI_ARADDR;
  logic               S_AXI_ARVALID;
  logic               S_AXI_ARREADY;
  logic [31:0]        S_AXI_RDATA;
  logic [1:0]         S_AXI_RRESP;
  logic               S_AXI_RVALID;
  logic               S_AXI_RREADY;
  logic               CONFIG_VALID;
  logic               CONFIG_READY;
  logic [32*NREG-1:0] CONFIG_DATA;
  logic               CONFIG_DONE;
  logic               CONFIG_IRQ;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
           CONFIG_READY, CONFIG_DONE,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
           CONFIG_VALID, CONFIG_DATA, CONFIG_IRQ
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
           CONFIG_READY, CONFIG_DONE,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
           CONFIG_VALID, CONFIG_DATA, CONFIG_IRQ
  );
endinterface

// File: rtl/axil_cmd_queue.sv
// AXI4-Lite argument register file; a doorbell write to ARG[0] snapshots all
// arguments into a command FIFO drained by the engine, with completion tracking.
module axil_cmd_queue #(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned NREG      = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 8
) (
  input logic             ACLK,
  input logic             ARESETN,
  axil_cmd_queue_if.slave s
);
  localparam int unsigned DATA_W = 32 * NREG;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
  typedef enum logic [2:0] {K_ARG, K_STATUS, K_CTRL, K_CYCLES, K_BAD} kind_t;

  function automatic kind_t decode(input logic [31:0] addr);
    logic [IDX_W-1:0] idx;
    kind_t            k;
    idx = addr[ADDR_W-1:2];
    k   = K_BAD;
    if (addr[31:ADDR_W] == ADDR_BASE[31:ADDR_W] && addr[1:0] == 2'b00) begin
      if (idx < IDX_W'(NREG))          k = K_ARG;
      else if (idx == IDX_W'(NREG))     k = K_STATUS;
      else if (idx == IDX_W'(NREG + 1)) k = K_CTRL;
      else if (idx == IDX_W'(NREG + 2)) k = K_CYCLES;
    end
    return k;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  w_state_t          w_state_q, w_next;
  r_state_t          r_state_q, r_next;
  logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic              awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic [1:0]        bresp_q, rresp_q, wr_resp_d, rd_resp_d;
  logic [31:0]       awaddr_q, rdata_q, rd_data_d;
  logic [31:0]       arg_q [NREG];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [7:0]        outstanding_q;
  logic [31:0]       cyc_cnt_q, cycles_q, status_word, merged0;
  logic              done_q, irq_en_q, irq_q;
  logic              aw_fire, wr_fire, ar_fire, strb_any, is_arg0;
  logic              fifo_full, fifo_empty, push, pop, done_acc, done_clr;
  kind_t             wr_kind, rd_kind;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] push_data;

  assign aw_fire    = awready_q && s.S_AXI_AWVALID;
  assign wr_fire    = wready_q && s.S_AXI_WVALID;
  assign ar_fire    = arready_q && s.S_AXI_ARVALID;
  assign wr_kind    = decode(awaddr_q);
  assign rd_kind    = decode(s.S_AXI_ARADDR);
  assign wr_idx     = awaddr_q[ADDR_W-1:2];
  assign rd_idx     = s.S_AXI_ARADDR[ADDR_W-1:2];
  assign strb_any   = |s.S_AXI_WSTRB;
  assign is_arg0    = (wr_kind == K_ARG) && (wr_idx == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign merged0    = merge(arg_q[0], s.S_AXI_WDATA, s.S_AXI_WSTRB);
  // Full is judged before any same-cycle pop, so a doorbell into a full FIFO always fails.
  assign push       = wr_fire && is_arg0 && strb_any && !fifo_full;
  assign pop        = !fifo_empty && s.CONFIG_READY;
  assign done_acc   = s.CONFIG_DONE && (outstanding_q != '0);
  assign done_clr   = wr_fire && (wr_kind == K_STATUS) && strb_any && s.S_AXI_WDATA[16];
  assign status_word = 32'({done_q, outstanding_q, 1'b0, fifo_empty, fifo_full, 5'(count_q)});

  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < NREG; i++)
      push_data[32*i +: 32] = (i == 0) ? merged0 : arg_q[i];
  end

  // Write channel FSM; handshake outputs are registered from the next state.
  always_comb begin
    w_next    = w_state_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = 1'b0;
    case (w_state_q)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (wr_fire) w_next = W_RESP;
      W_RESP:  if (s.S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    awready_d = (w_next == W_IDLE);
    wready_d  = (w_next == W_DATA);
    bvalid_d  = (w_next == W_RESP);
  end

  always_comb begin
    wr_resp_d = RESP_OKAY;
    if (wr_kind == K_BAD || wr_kind == K_CYCLES || (is_arg0 && strb_any && fifo_full))
      wr_resp_d = RESP_SLVERR;
  end

  // Read channel FSM and read-data mux.
  always_comb begin
    r_next    = r_state_q;
    arready_d = 1'b0;
    rvalid_d  = 1'b0;
    case (r_state_q)
      R_IDLE:  if (ar_fire) r_next = R_DATA;
      R_DATA:  if (s.S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
    arready_d = (r_next == R_IDLE);
    rvalid_d  = (r_next == R_DATA);
  end

  always_comb begin
    rd_data_d = '0;
    rd_resp_d = RESP_OKAY;
    case (rd_kind)
      K_ARG: begin
        for (int unsigned i = 0; i < NREG; i++)
          if (rd_idx == IDX_W'(i)) rd_data_d = arg_q[i];
      end
      K_STATUS: rd_data_d = status_word;
      K_CTRL:   rd_data_d = 32'(irq_en_q);
      K_CYCLES: rd_data_d = cycles_q;
      default:  rd_resp_d = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      awaddr_q  <= '0;
    end else begin
      w_state_q <= w_next;
      r_state_q <= r_next;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (aw_fire) awaddr_q <= s.S_AXI_AWADDR;
      if (wr_fire) bresp_q <= wr_resp_d;
      if (ar_fire) begin
        rdata_q <= rd_data_d;
        rresp_q <= rd_resp_d;
      end
    end
  end

  // Register file, FIFO bookkeeping and completion tracking.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NREG; i++) arg_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      cyc_cnt_q     <= '0;
      cycles_q      <= '0;
      done_q        <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      if (wr_fire && wr_kind == K_ARG) begin
        for (int unsigned i = 0; i < NREG; i++)
          if (wr_idx == IDX_W'(i) && (i != 0 || push))
            arg_q[i] <= merge(arg_q[i], s.S_AXI_WDATA, s.S_AXI_WSTRB);
      end
      if (wr_fire && wr_kind == K_CTRL && s.S_AXI_WSTRB[0]) irq_en_q <= s.S_AXI_WDATA[0];
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
      case ({pop, done_acc})
        2'b10:   if (outstanding_q != 8'hFF) outstanding_q <= outstanding_q + 8'd1;
        2'b01:   outstanding_q <= outstanding_q - 8'd1;
        default: ;
      endcase
      if (done_acc) begin
        cycles_q  <= cyc_cnt_q + 32'd1;
        cyc_cnt_q <= '0;
      end else if (outstanding_q != '0) begin
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end
      // A completion in the same cycle as a W1C wins, so done stays set.
      if (done_acc)      done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
      irq_q <= irq_en_q && done_q;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign s.S_AXI_AWREADY = awready_q;
  assign s.S_AXI_WREADY  = wready_q;
  assign s.S_AXI_BVALID  = bvalid_q;
  assign s.S_AXI_BRESP   = bresp_q;
  assign s.S_AXI_ARREADY = arready_q;
  assign s.S_AXI_RVALID  = rvalid_q;
  assign s.S_AXI_RDATA   = rdata_q;
  assign s.S_AXI_RRESP   = rresp_q;
  assign s.CONFIG_VALID  = !fifo_empty;
  assign s.CONFIG_DATA   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign s.CONFIG_IRQ    = irq_q;
endmodule

// File: doc/axil_cmd_queue.md
Name: axil_cmd_queue

Overview:
- Parametrised AXI4-Lite command register file with a queued command interface to a compute/DMA engine.
- Host writes NREG argument words; a write to word 0 (doorbell) snapshots all NREG words into a DEPTH-entry FIFO.
- The FIFO drains over a valid/ready command port. Per-command cycle count, outstanding count, sticky done flag and a maskable level IRQ are exposed to the host.
- Sits between the PS general-purpose AXI port (after lite conversion) and the accelerator top.

Parameters:
- ADDR_BASE, 32'h0, base address; bits [ADDR_W-1:0] are ignored for match.
- NREG, 4, argument words per command (2..32).
- DEPTH, 4, command FIFO entries (power of 2, 2..16).
- ADDR_W, 8, local address bits decoded (must cover 4*NREG+12).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  32  write address
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  write byte strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  32  read address
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- CONFIG_VALID  out  1  FIFO head valid
- CONFIG_READY  in  1  engine accepts command
- CONFIG_DATA  out  32*NREG  head command; word i at [32i+31:32i]
- CONFIG_DONE  in  1  one-cycle pulse: engine finished one command
- CONFIG_IRQ  out  1  level interrupt

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - All *READY, *VALID, CONFIG_IRQ = 0.
  - RESP = 00, RDATA = 0.
  - Argument regs, FIFO pointers, counters, done, irq_en = 0.
- Map (offset = addr[ADDR_W-1:0]):
  - 4*i, i < NREG: ARG[i], RW.
  - 4*NREG: STATUS. Read: [4:0] fifo count, [5] full, [6] empty, [15:8] outstanding, [16] done. Write: bit16 = 1 clears done (W1C); other bits ignored.
  - 4*NREG+4: CTRL, RW. [0] irq_en.
  - 4*NREG+8: CYCLES, RO. Cycle count of last completed command.
- Address match: addr[31:ADDR_W] == ADDR_BASE[31:ADDR_W], offset mapped, and addr[1:0] == 0; otherwise SLVERR with no side effect (reads return 0).
- Write channel (FSM W_IDLE, W_DATA, W_RESP):
  - W_IDLE: AWREADY = 1. On AWVALID, latch address and go to W_DATA.
  - W_DATA: WREADY = 1. On WVALID, perform the write, go to W_RESP.
  - W_RESP: BVALID = 1 until BREADY, then W_IDLE.
  - One transaction outstanding.
- Byte strobes apply to ARG and CTRL; zero-strobe write is a legal no-op (OKAY).
- Doorbell: a write to ARG[0] with FIFO not full updates ARG[0] and pushes {ARG[NREG-1..1], merged new ARG[0]} the same cycle.
  - With FIFO full: no update, no push, SLVERR.
- Write to CYCLES: SLVERR, ignored.
- Read channel (R_IDLE, R_DATA):
  - R_IDLE: ARREADY = 1. On ARVALID, register RDATA/RRESP and go to R_DATA.
  - R_DATA: RVALID = 1 (one cycle after AR handshake), held stable until RREADY.
- FIFO: CONFIG_VALID = !empty; CONFIG_DATA = head, stable while VALID && !READY.
  - Pop on VALID && READY. Simultaneous push and pop when full: push rejected (full evaluated pre-pop).
  - Simultaneous push and pop when non-full: both occur, count unchanged.
- outstanding: +1 on pop, -1 on CONFIG_DONE; both in one cycle leaves it unchanged. DONE with outstanding = 0 is ignored. Saturates at 255.
- Cycle counter: increments each cycle outstanding != 0.
  - On an accepted DONE, CYCLES <= counter+1, counter <= 0, done <= 1.
- A W1C clear of done coincident with a DONE leaves done = 1.
- CONFIG_IRQ = irq_en && done, registered (1-cycle delay).

Test Plan:
- NREG=4: write ARG1..3 = 0x11, 0x22, 0x33, then ARG0 = 0xA5 -> one cycle later CONFIG_VALID = 1, CONFIG_DATA = {0x33, 0x22, 0x11, 0xA5}; BRESP = OKAY.
- CONFIG_READY = 0, DEPTH = 4: five doorbells -> first four OKAY, STATUS count = 4, full = 1; fifth SLVERR and ARG0 unchanged; readback confirms.
- Pop one command, hold 9 cycles, pulse CONFIG_DONE -> CYCLES reads 10, STATUS done = 1, outstanding = 0; with irq_en = 1, IRQ rises one cycle after done; writing STATUS bit16 clears IRQ.
- Write ARG2 = 0xFFFFFFFF, then ARG2 = 0x00000000 with WSTRB = 4'b0010 -> reads 0xFFFF00FF.
- Read offset 0x44 with NREG=4 -> SLVERR, RDATA = 0; RREADY held low 5 cycles -> RVALID/RDATA stable.
- Assert ARESETN low mid write (after AW, before W) and with 2 queued commands -> all outputs 0 immediately; after release FIFO empty, ARG reads 0, next write completes normally.
